// File: rtl/gate_truth_checker.sv
// On-chip truth-table checker for small combinational gates.
// Sweeps every input vector, waits SETTLE cycles, compares against EXPECT.
module gate_truth_checker #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1001
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            dut_out_i,
  output logic [N_IN-1:0] stim_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            pass_o,
  output logic [N_IN:0]   err_count_o,
  output logic            fail_valid_o,
  output logic [N_IN-1:0] first_fail_vec_o
);

  localparam int NV = 1 << N_IN;
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] VMAX  = N_IN'(NV - 1);
  localparam logic [SW-1:0]   SLAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN:0]   err_q, err_d;
  logic            fv_q, fv_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic            mism;

  // 4-state compare so an X/Z gate output is flagged in simulation
  always_comb begin
    mism = (dut_out_i !== EXPECT[vec_q]);
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    err_d    = err_q;
    fv_d     = fv_q;
    ff_d     = ff_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = APPLY;
          vec_d    = '0;
          stim_d   = '0;
          settle_d = '0;
          err_d    = '0;
          fv_d     = 1'b0;
          ff_d     = '0;
        end
      end
      APPLY: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SLAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (mism) begin
          err_d = err_q + (N_IN+1)'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        if (vec_q == VMAX) begin
          state_d = DONE;
        end else begin
          state_d  = APPLY;
          vec_d    = vec_q + N_IN'(1);
          stim_d   = vec_q + N_IN'(1);
          settle_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      stim_q   <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fv_q     <= 1'b0;
      ff_q     <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      ff_q     <= ff_d;
    end
  end

  assign stim_o           = stim_q;
  assign busy_o           = (state_q == APPLY) || (state_q == CHECK);
  assign done_o           = (state_q == DONE);
  assign pass_o           = (state_q == DONE) && (err_q == '0);
  assign err_count_o      = err_q;
  assign fail_valid_o     = fv_q;
  assign first_fail_vec_o = ff_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized self-checking bench for gate_truth_checker.
// The gate-under-test is a lookup table the bench chooses per sweep.
module tb_gate_truth_checker;

  localparam logic [3:0] EXP_TT = 4'b1001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       dut_out;
  logic [1:0] stim;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] first_fail_vec;
  logic [3:0] gut_tbl = EXP_TT;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign dut_out = gut_tbl[stim];

  gate_truth_checker #(
    .N_IN  (2),
    .SETTLE(2),
    .EXPECT(EXP_TT)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .dut_out_i       (dut_out),
    .stim_o          (stim),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_count_o     (err_count),
    .fail_valid_o    (fail_valid),
    .first_fail_vec_o(first_fail_vec)
  );

  task automatic test_reset(input string tag);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if (stim !== 2'd0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || err_count !== 3'd0 ||
        fail_valid !== 1'b0 || first_fail_vec !== 2'd0) begin
      nerr++;
      $display("FAIL %s: stim=%0d busy=%b done=%b pass=%b err=%0d fv=%b ff=%0d want all zero",
               tag, stim, busy, done, pass, err_count, fail_valid, first_fail_vec);
    end
    rst = 1'b0;
  endtask

  // hold: keep start high across the sweep; poke: random start pulses while busy
  task automatic run_sweep(input string tag, input logic [3:0] tbl,
                           input bit hold, input bit poke);
    int  exp_err = 0;
    int  exp_ff  = 0;
    bit  exp_fv  = 0;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i] != EXP_TT[i]) begin
        exp_err++;
        if (!exp_fv) begin
          exp_fv = 1;
          exp_ff = i;
        end
      end
    end
    gut_tbl = tbl;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!hold) start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      nvec++;
      if (stim !== 2'(c / 3) || busy !== 1'b1 || done !== 1'b0) begin
        nerr++;
        $display("FAIL %s cycle %0d: stim=%0d busy=%b done=%b want stim=%0d busy=1 done=0",
                 tag, c, stim, busy, done, c / 3);
      end
      if (c == 0) begin
        nvec++;
        if (err_count !== 3'd0 || fail_valid !== 1'b0) begin
          nerr++;
          $display("FAIL %s clear: err=%0d fv=%b want 0 0", tag, err_count, fail_valid);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    nvec++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== (exp_err == 0) ||
        err_count !== 3'(exp_err) || fail_valid !== exp_fv || stim !== 2'd3) begin
      nerr++;
      $display("FAIL %s result: done=%b busy=%b pass=%b err=%0d fv=%b stim=%0d want 1 0 %b %0d %b 3",
               tag, done, busy, pass, err_count, fail_valid, stim,
               exp_err == 0, exp_err, exp_fv);
    end
    if (exp_fv) begin
      nvec++;
      if (first_fail_vec !== 2'(exp_ff)) begin
        nerr++;
        $display("FAIL %s first_fail: got %0d want %0d", tag, first_fail_vec, exp_ff);
      end
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b1 || stim !== 2'd3 || err_count !== 3'(exp_err)) begin
      nerr++;
      $display("FAIL %s hold: done=%b stim=%0d err=%0d want 1 3 %0d",
               tag, done, stim, err_count, exp_err);
    end
  endtask

  task automatic test_golden;
    run_sweep("golden", 4'b1001, 0, 0);
  endtask

  task automatic test_stuck1;
    run_sweep("stuck1", 4'b1111, 0, 0);
  endtask

  task automatic test_xor;
    run_sweep("xor", 4'b0110, 0, 0);
  endtask

  task automatic test_mid_reset;
    gut_tbl = 4'b0000;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    nvec++;
    if (stim !== 2'd2 || err_count === 3'd0) begin
      nerr++;
      $display("FAIL mid_pre: stim=%0d err=%0d want 2 nonzero", stim, err_count);
    end
    test_reset("mid_reset");
    run_sweep("post_reset", 4'b1001, 0, 0);
  endtask

  task automatic test_hold_start;
    run_sweep("hold_start", 4'b1001, 1, 0);
  endtask

  task automatic test_restart_in_done;
    run_sweep("restart_a", 4'b1111, 0, 0);
    run_sweep("restart_b", 4'b1001, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 12; n++) begin
      run_sweep("random", 4'($urandom_range(0, 15)), 0, 1);
    end
  endtask

  initial begin
    test_reset("reset");
    test_golden;
    test_stuck1;
    test_xor;
    test_mid_reset;
    test_hold_start;
    test_restart_in_done;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
